// File: rtl/systolic_result_drain.sv
// Snapshots an N x N block of signed accumulator results and streams it out row-major over valid/ready.
// Optional build macro DRAIN_RELU_EN: negative results are clamped to zero as the snapshot is loaded.
module systolic_result_drain #(
  parameter int DATA_WIDTH = 8,
  parameter int N          = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           capture,
  input  logic [N*N*2*DATA_WIDTH-1:0]    results_flat,
  output logic [2*DATA_WIDTH-1:0]        out_data,
  output logic [$clog2(N)-1:0]           out_row,
  output logic [$clog2(N)-1:0]           out_col,
  output logic                           out_last,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic                           busy,
  output logic                           overrun
);

  localparam int RW = 2 * DATA_WIDTH;
  localparam int NE = N * N;
  localparam int IW = $clog2(NE);
  localparam int CW = $clog2(N);
  localparam logic [IW-1:0] LAST_IDX = IW'(NE - 1);
  localparam logic [IW-1:0] IDX_ONE  = {{(IW-1){1'b0}}, 1'b1};

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } state_t;

  state_t          state_r;
  state_t          state_nxt_s;
  logic [IW-1:0]   index_r;
  logic [IW-1:0]   index_nxt_s;
  logic [RW-1:0]   snap_r [NE];
  logic            xfer_s;
  logic            at_last_s;
  logic            load_s;
  logic            overrun_nxt_s;
  logic [RW-1:0]   data_nxt_s;
  logic [CW-1:0]   row_nxt_s;
  logic [CW-1:0]   col_nxt_s;
  logic            last_nxt_s;
  logic            valid_nxt_s;

  function automatic logic [RW-1:0] load_value(input logic [RW-1:0] v);
`ifdef DRAIN_RELU_EN
    return v[RW-1] ? {RW{1'b0}} : v;
`else
    return v;
`endif
  endfunction

  // State and element index register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
      index_r <= {IW{1'b0}};
    end else begin
      state_r <= state_nxt_s;
      index_r <= index_nxt_s;
    end
  end

  // Next state: a capture is taken only when idle or on the final transfer of a frame
  always_comb begin
    xfer_s        = out_valid & out_ready;
    at_last_s     = (index_r == LAST_IDX);
    state_nxt_s   = state_r;
    index_nxt_s   = index_r;
    load_s        = 1'b0;
    overrun_nxt_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (capture) begin
          state_nxt_s = STREAM;
          index_nxt_s = {IW{1'b0}};
          load_s      = 1'b1;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      STREAM: begin
        if (xfer_s && at_last_s) begin
          index_nxt_s = {IW{1'b0}};
          if (capture) begin
            load_s      = 1'b1;
            state_nxt_s = STREAM;
          end else begin
            state_nxt_s = IDLE;
          end
        end else if (xfer_s) begin
          index_nxt_s   = index_r + IDX_ONE;
          overrun_nxt_s = capture;
        end else begin
          overrun_nxt_s = capture;
        end
      end
      default: begin
        state_nxt_s = IDLE;
        index_nxt_s = {IW{1'b0}};
      end
    endcase
  end

  // Snapshot buffer; reset need not clear it but does suppress a coincident load
  always_ff @(posedge clk) begin
    if (load_s && !rst) begin
      for (int k = 0; k < NE; k++) begin
        snap_r[k] <= load_value(results_flat[k*RW +: RW]);
      end
    end
  end

  // Output values for the next cycle; a fresh load bypasses the buffer for element (0,0)
  always_comb begin
    data_nxt_s  = {RW{1'b0}};
    row_nxt_s   = {CW{1'b0}};
    col_nxt_s   = {CW{1'b0}};
    last_nxt_s  = 1'b0;
    valid_nxt_s = 1'b0;
    if (state_nxt_s == STREAM) begin
      valid_nxt_s = 1'b1;
      row_nxt_s   = CW'(int'(index_nxt_s) / N);
      col_nxt_s   = CW'(int'(index_nxt_s) % N);
      last_nxt_s  = (index_nxt_s == LAST_IDX);
      if (load_s) begin
        data_nxt_s = load_value(results_flat[RW-1:0]);
      end else begin
        data_nxt_s = snap_r[index_nxt_s];
      end
    end else begin
      valid_nxt_s = 1'b0;
    end
  end

  // Registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      out_data  <= {RW{1'b0}};
      out_row   <= {CW{1'b0}};
      out_col   <= {CW{1'b0}};
      out_last  <= 1'b0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      out_data  <= data_nxt_s;
      out_row   <= row_nxt_s;
      out_col   <= col_nxt_s;
      out_last  <= last_nxt_s;
      out_valid <= valid_nxt_s;
      busy      <= valid_nxt_s;
      overrun   <= overrun_nxt_s;
    end
  end

endmodule

// File: tb/tb_systolic_result_drain.sv
// Randomized bench for systolic_result_drain, checked against a queue model of pending elements.
module tb_systolic_result_drain;

  localparam int DW  = 8;
  localparam int N   = 2;
  localparam int RW  = 2 * DW;
  localparam int NE  = N * N;
  localparam int TOT = NE * RW;
  localparam int CW  = $clog2(N);

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           capture = 1'b0;
  logic [TOT-1:0] results_flat = '0;
  logic [RW-1:0]  out_data;
  logic [CW-1:0]  out_row;
  logic [CW-1:0]  out_col;
  logic           out_last;
  logic           out_valid;
  logic           out_ready = 1'b0;
  logic           busy;
  logic           overrun;

  systolic_result_drain #(.DATA_WIDTH(DW), .N(N)) dut (
    .clk          (clk),
    .rst          (rst),
    .capture      (capture),
    .results_flat (results_flat),
    .out_data     (out_data),
    .out_row      (out_row),
    .out_col      (out_col),
    .out_last     (out_last),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .busy         (busy),
    .overrun      (overrun)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [RW-1:0] d;
    int            r;
    int            c;
    logic          l;
  } ent_t;

  ent_t q[$];
  int   checks = 0;
  int   failures = 0;
  bit   known = 1'b0;
  bit   after_rst = 1'b0;
  bit   exp_ov = 1'b0;

  // Basic frame: (0,0)=5 (0,1)=-3 (1,0)=300 (1,1)=-32768
  localparam logic [TOT-1:0] BASIC = {16'h8000, 16'h012C, 16'hFFFD, 16'h0005};

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic push_frame(input logic [TOT-1:0] res);
    ent_t e;
    for (int k = 0; k < NE; k++) begin
      e.d = res[k*RW +: RW];
`ifdef DRAIN_RELU_EN
      if (e.d[RW-1]) e.d = '0;
`endif
      e.r = k / N;
      e.c = k % N;
      e.l = (k == NE - 1);
      q.push_back(e);
    end
  endtask

  // Model of one rising edge: the frame ahead of the DUT is the queue of elements still owed
  task automatic model_edge(input logic r, input logic c, input logic rd, input logic [TOT-1:0] res);
    bit xfer;
    bit fin;
    bit acc;
    if (r) begin
      q.delete();
      exp_ov    = 1'b0;
      known     = 1'b1;
      after_rst = 1'b1;
    end else begin
      after_rst = 1'b0;
      xfer   = (q.size() > 0) && rd;
      fin    = xfer && (q.size() == 1);
      acc    = c && ((q.size() == 0) || fin);
      exp_ov = c && !acc;
      if (xfer) void'(q.pop_front());
      if (acc) push_frame(res);
    end
  endtask

  task automatic check_outputs();
    check_eq("out_valid", 32'(out_valid), 32'(q.size() > 0));
    check_eq("busy", 32'(busy), 32'(q.size() > 0));
    check_eq("overrun", 32'(overrun), 32'(exp_ov));
    if (q.size() > 0) begin
      check_eq("out_data", 32'(out_data), 32'(q[0].d));
      check_eq("out_row", 32'(out_row), 32'(q[0].r));
      check_eq("out_col", 32'(out_col), 32'(q[0].c));
      check_eq("out_last", 32'(out_last), 32'(q[0].l));
    end
    if (after_rst) begin
      check_eq("rst_data", 32'(out_data), 32'h0);
      check_eq("rst_row", 32'(out_row), 32'h0);
      check_eq("rst_col", 32'(out_col), 32'h0);
      check_eq("rst_last", 32'(out_last), 32'h0);
    end
  endtask

  task automatic step(input logic r, input logic c, input logic rd, input logic [TOT-1:0] res);
    @(negedge clk);
    if (known) check_outputs();
    rst          = r;
    capture      = c;
    out_ready    = rd;
    results_flat = res;
    model_edge(r, c, rd, res);
  endtask

  function automatic logic [TOT-1:0] rand_res();
    logic [TOT-1:0] v;
    v = '0;
    for (int k = 0; k < NE; k++) begin
      v[k*RW +: RW] = RW'($urandom);
      if ($urandom_range(0, 7) == 0) v[k*RW +: RW] = 16'h8000;
    end
    return v;
  endfunction

  initial begin
    step(1'b1, 1'b0, 1'b0, '0);
    step(1'b1, 1'b0, 1'b0, '0);

    // Basic drain at full throughput
    step(1'b0, 1'b1, 1'b1, BASIC);
    repeat (NE + 1) step(1'b0, 1'b0, 1'b1, '0);

    // Backpressure on element (0,1)
    step(1'b0, 1'b1, 1'b1, BASIC);
    step(1'b0, 1'b0, 1'b1, '0);
    repeat (3) step(1'b0, 1'b0, 1'b0, '0);
    repeat (NE + 1) step(1'b0, 1'b0, 1'b1, '0);

    // Overrun: second capture mid-frame
    step(1'b0, 1'b1, 1'b1, BASIC);
    step(1'b0, 1'b0, 1'b1, '0);
    step(1'b0, 1'b1, 1'b1, rand_res());
    repeat (NE + 1) step(1'b0, 1'b0, 1'b1, '0);

    // Back-to-back: capture on the final transfer edge
    step(1'b0, 1'b1, 1'b1, BASIC);
    while (q.size() > 1) step(1'b0, 1'b0, 1'b1, '0);
    step(1'b0, 1'b1, 1'b1, rand_res());
    repeat (NE + 1) step(1'b0, 1'b0, 1'b1, '0);

    // Reset mid-stream, capture coincident with reset, then a fresh frame
    step(1'b0, 1'b1, 1'b1, BASIC);
    step(1'b0, 1'b0, 1'b1, '0);
    step(1'b0, 1'b0, 1'b1, '0);
    step(1'b1, 1'b1, 1'b1, rand_res());
    step(1'b0, 1'b1, 1'b1, rand_res());
    repeat (NE + 1) step(1'b0, 1'b0, 1'b1, '0);

    // Randomized traffic
    repeat (3000) begin
      step(1'($urandom_range(0, 199) == 0), 1'($urandom_range(0, 5) == 0),
           1'($urandom_range(0, 9) < 7), rand_res());
    end
    step(1'b0, 1'b0, 1'b0, '0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/systolic_result_drain.md
Name: systolic_result_drain

Overview:
- Output-side collector for the N×N systolic array of processing elements.
- On a capture pulse, snapshots all N*N signed accumulator results in one cycle.
- Then streams them out one element per handshake, row-major, over a valid/ready interface to the downstream writer (result memory or host DMA).
- Frees the array to start the next multiplication while the previous result is draining.

Parameters:
- DATA_WIDTH, 8, operand width of the array; each result is 2*DATA_WIDTH bits, signed.
- N, 4, array dimension; N*N results per frame; N >= 2.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- capture  input  1  one-cycle pulse: results_flat holds a complete, settled result set
- results_flat  input  N*N*2*DATA_WIDTH  packed results; element (r,c) occupies bits [(r*N+c+1)*2*DATA_WIDTH-1 -: 2*DATA_WIDTH]
- out_data  output  2*DATA_WIDTH  current result, signed
- out_row  output  clog2(N)  row index of out_data
- out_col  output  clog2(N)  column index of out_data
- out_last  output  1  high with the final element (N-1,N-1) of a frame
- out_valid  output  1  out_data, out_row, out_col and out_last are valid
- out_ready  input  1  downstream accepts the element
- busy  output  1  high in STREAM
- overrun  output  1  one-cycle pulse: capture was dropped

Behaviour:
- One clock, clk; reset is synchronous and active-high on rst, sampled only at a rising clk edge.
- Reset values: out_data=0, out_row=0, out_col=0, out_last=0, out_valid=0, busy=0, overrun=0, state=IDLE, index=0. The snapshot buffer need not be cleared.
- FSM states: IDLE, STREAM.
- IDLE, capture=1:
  - At this edge, copy all N*N elements into the buffer and set index=0.
  - Go to STREAM; out_valid=1 and busy=1 from the next cycle.
  - Latency: capture at edge t gives out_valid at t+1 with element (0,0).
- STREAM outputs:
  - out_data = buf[index]; out_row = index / N; out_col = index % N; out_last = (index == N*N-1).
  - All outputs are registered.
- Handshake:
  - A transfer occurs on any edge with out_valid && out_ready.
  - While out_valid && !out_ready, all outputs hold stable.
  - out_valid never drops without a transfer, except on reset.
- Transfer with index < N*N-1: index increments; the next element is presented in the following cycle. Full throughput is one element per cycle when out_ready is held high.
- Transfer with index == N*N-1:
  - If capture=1 at the same edge: the new frame is snapshotted and index=0. out_valid stays 1 and element (0,0) of the new frame appears next cycle (back-to-back frames).
  - Otherwise: go to IDLE; out_valid=0 and busy=0 next cycle.
- capture=1 in STREAM, other than on the final-transfer edge:
  - The capture is ignored and the buffer is untouched.
  - overrun pulses high for exactly one cycle.
- capture with rst=1: reset wins; no snapshot, no overrun.
- Reset mid-frame: stream abandoned; out_valid=0 after the edge; no partial completion is signalled.
- out_ready is ignored in IDLE.
- Data passes through unmodified: signed 2*DATA_WIDTH, no truncation (unless the optional feature below is compiled in).
- Frame length is always exactly N*N transfers, with out_last on the last one only.

Optional Feature:
- Macro: DRAIN_RELU_EN.
- When defined: any negative element (sign bit set) is replaced by 0 on out_data. The substitution is applied when the buffer is loaded, so out_data timing is unchanged. Indices, out_last and the handshake are unaffected.
- When undefined: out_data is the raw signed result.

Test Plan:
- Basic drain (N=2, DATA_WIDTH=8): results (0,0)=5, (0,1)=-3, (1,0)=300, (1,1)=-32768; capture pulse with out_ready=1 -> four consecutive cycles out_data=0x0005, 0xFFFD, 0x012C, 0x8000; row/col (0,0),(0,1),(1,0),(1,1); out_last only on the 4th; out_valid low the cycle after.
- Backpressure: same frame, out_ready low for 3 cycles on element (0,1) -> out_data=0xFFFD, out_row=0, out_col=1 held stable all 3 cycles; no element skipped or duplicated; 4 transfers total.
- Overrun: second capture mid-frame with a different result set -> overrun high exactly 1 cycle; remaining outputs come from the first frame.
- Back-to-back: capture asserted on the edge of the out_last transfer -> out_valid stays high; next cycle shows new element (0,0); busy never drops.
- Reset mid-stream: rst after 2 transfers -> next cycle out_valid=0, busy=0, out_row=out_col=0; a fresh capture then streams from (0,0).
- DRAIN_RELU_EN defined, basic-drain frame -> outputs 0x0005, 0x0000, 0x012C, 0x0000.
